// File: rtl/mem_byte_seq.sv
// Byte-serial big-endian memory: one byte per clock, access latency = size in bytes (1/2/4).
// MOC is registered and asserts the edge after the last byte; it holds until MOV drops.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word requests finish at once with ALIGN_ERR.
module mem_byte_seq #(
    parameter int ADDR_BITS = 8
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  typeData,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        ALIGN_ERR
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Storage is deliberately outside the reset domain so CLR never clears it.
    logic [7:0] mem [0:DEPTH-1];

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   rw_q, rw_d;
    logic [1:0]             last_q, last_d;   // index of the final byte (0, 1 or 3)
    logic [1:0]             idx_q, idx_d;
    logic [31:0]            asm_q, asm_d;
    logic [31:0]            dout_q, dout_d;
    logic                   moc_q, moc_d;
    logic                   aerr_q, aerr_d;

    logic [ADDR_BITS-1:0]   cur_addr;
    logic [1:0]             bsel;
    logic [7:0]             wr_byte;
    logic [7:0]             rd_byte;
    logic                   mem_we;
    logic                   misalign;

    // Upper address bits are outside the implemented space.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[31:ADDR_BITS];

    // Byte i of the access sits at A+i, wrapping at the top of memory.
    assign cur_addr = addr_q + ADDR_BITS'(idx_q);
    // Big-endian: byte i of the transfer is operand byte (n-1-i).
    assign bsel     = last_q - idx_q;
    assign wr_byte  = data_q[{bsel, 3'b000} +: 8];
    assign rd_byte  = mem[cur_addr];

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ((typeData == 2'b01) && Address[0]) ||
                      (typeData[1] && (Address[1:0] != 2'b00));
    assign ALIGN_ERR = aerr_q;
`else
    assign misalign  = 1'b0;
    assign ALIGN_ERR = 1'b0;
`endif

    assign DataOut = dout_q;
    assign MOC     = moc_q;

    // Next-state, operand latching, byte assembly and write strobe.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = rw_q;
        last_d  = last_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        dout_d  = dout_q;
        aerr_d  = aerr_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MOV) begin
                    addr_d = Address[ADDR_BITS-1:0];
                    data_d = DataIn;
                    rw_d   = RW;
                    idx_d  = 2'd0;
                    unique case (typeData)
                        2'b00:   last_d = 2'd0;
                        2'b01:   last_d = 2'd1;
                        default: last_d = 2'd3;
                    endcase
                    if (misalign) begin
                        state_d = DONE;
                        aerr_d  = 1'b1;
                    end else begin
                        state_d = XFER;
                        if (RW) begin
                            asm_d = 32'd0;
                        end
                    end
                end
            end
            XFER: begin
                if (rw_q) begin
                    asm_d = {asm_q[23:0], rd_byte};
                end else begin
                    mem_we = 1'b1;
                end
                if (idx_q == last_q) begin
                    state_d = DONE;
                    if (rw_q) begin
                        dout_d = {asm_q[23:0], rd_byte};
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            DONE: begin
                if (!MOV) begin
                    state_d = IDLE;
                    aerr_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        moc_d = (state_d == DONE);
    end

    // Control and datapath registers; CLR aborts any access immediately.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            last_q  <= 2'd0;
            idx_q   <= 2'd0;
            asm_q   <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            aerr_q  <= aerr_d;
        end
    end

    // One byte written per XFER edge; suppressed while CLR is held.
    always_ff @(posedge CLK) begin
        if (mem_we && !CLR) begin
            mem[cur_addr] <= wr_byte;
        end
    end

endmodule
